piso_serializer: RTL and testbench

- Parallel-in/serial-out stage sitting directly upstream of the overlapping sequence detectors.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Emits one bit per clock on ser_out, which drives the detector's serial input x, plus bit framing.
- Supports gapless back-to-back words, so overlapping patterns across word boundaries reach the detector intact.

---
 rtl/serial_pkg.sv | 30 +++
 rtl/piso_serializer_if.sv | 12 +
 rtl/piso_serializer.sv | 128 ++++++++++++
 tb/tb_piso_serializer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial front-end blocks: FSM state encoding,
// frame-length rule and a constant-foldable ceil(log2) helper.
// Optional build macro: PISO_PARITY_EN (appends an even-parity bit per frame).
package serial_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  // Bits per frame: data bits, plus one parity bit when enabled.
  function automatic int unsigned frame_len(input int unsigned width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  // ceil(log2(v)); returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-level valid/ready handshake into the serializer.
// master = upstream word source, slave = serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding a serial sequence detector.
// Accepts WIDTH-bit words over valid/ready, emits one registered bit per
// clock with bit_valid/last_bit framing; back-to-back words are gapless.
// Optional build macro: PISO_PARITY_EN (one even-parity bit after the data).
module piso_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  piso_serializer_if.slave     up,
  output logic                 ser_out,
  output logic                 bit_valid,
  output logic                 last_bit,
  output logic                 busy
);

  localparam int unsigned FRAME    = frame_len(WIDTH);
  localparam int unsigned CW       = (clog2(FRAME) < 1) ? 1 : clog2(FRAME);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             ser_q,   ser_d;
  logic             vld_q,   vld_d;
  logic             last_q,  last_d;
  logic             xfer;
`ifdef PISO_PARITY_EN
  logic             par_q,   par_d;
`endif

  // Bit presented next from a word, honouring the configured bit order.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Word with its head bit consumed.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready while idle, or on the final bit so the next word follows with no gap.
  always_comb begin
    up.in_ready = (state_q == S_IDLE) || ((state_q == S_SHIFT) && last_q);
    xfer        = up.in_valid && up.in_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: enter SHIFT on a transfer, leave only after an unreloaded last bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (xfer) state_d = S_SHIFT;
      S_SHIFT: if (last_q && !xfer) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values: the first bit is presented in the cycle right
  // after the accepting edge, so the load path drives ser_d directly from
  // in_data and the shift register keeps only the not-yet-sent bits.
  always_comb begin
    shreg_d = '0;
    cnt_d   = '0;
    ser_d   = 1'b0;
    vld_d   = 1'b0;
    last_d  = 1'b0;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    if (xfer) begin
      shreg_d = shift_word(up.in_data);
      cnt_d   = '0;
      ser_d   = head_bit(up.in_data);
      vld_d   = 1'b1;
      last_d  = 1'b0;
`ifdef PISO_PARITY_EN
      par_d   = ^up.in_data;
`endif
    end else if ((state_q == S_SHIFT) && !last_q) begin
      shreg_d = shift_word(shreg_q);
      cnt_d   = cnt_q + CW'(1);
      ser_d   = head_bit(shreg_q);
`ifdef PISO_PARITY_EN
      if (cnt_d == LAST_CNT) ser_d = par_q;
`endif
      vld_d   = 1'b1;
      last_d  = (cnt_d == LAST_CNT);
    end
  end

  // Datapath and framing registers; reset drops any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign ser_out   = ser_q;
  assign bit_valid = vld_q;
  assign last_bit  = last_q;
  assign busy      = vld_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: two instances (WIDTH=5 MSB-first and
// WIDTH=8 LSB-first) share clock and reset. Drivers push the expected bit
// frame on each accepted word; per-instance monitors pop and compare.
module tb_piso_serializer;

  localparam int unsigned WA = 5;
  localparam int unsigned WB = 8;
`ifdef PISO_PARITY_EN
  localparam int unsigned FA = WA + 1;
  localparam int unsigned FB = WB + 1;
`else
  localparam int unsigned FA = WA;
  localparam int unsigned FB = WB;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } ebit_t;

  logic clk;
  logic rst_n;
  logic a_ser, a_bv, a_last, a_busy;
  logic b_ser, b_bv, b_last, b_busy;

  piso_serializer_if #(.WIDTH(WA)) ifa ();
  piso_serializer_if #(.WIDTH(WB)) ifb ();

  piso_serializer #(.WIDTH(WA), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .up(ifa),
    .ser_out(a_ser), .bit_valid(a_bv), .last_bit(a_last), .busy(a_busy)
  );

  piso_serializer #(.WIDTH(WB), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .up(ifb),
    .ser_out(b_ser), .bit_valid(b_bv), .last_bit(b_last), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  ebit_t qa[$];
  ebit_t qb[$];
  logic [63:0] stream_a, stream_b;
  int    na, nb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: bit k of the frame in r[k]; r[width] is even parity.
  function automatic logic [32:0] frame_bits(input int unsigned width, input bit msb,
                                             input logic [31:0] w);
    logic [32:0] r;
    logic p;
    r = '0;
    p = 1'b0;
    for (int unsigned k = 0; k < width; k++) begin
      r[k] = msb ? w[width-1-k] : w[k];
      p    = p ^ w[k];
    end
    r[width] = p;
    return r;
  endfunction

  task automatic push_a(input logic [31:0] w);
    logic [32:0] r;
    r = frame_bits(WA, 1'b1, w);
    for (int unsigned k = 0; k < FA; k++) qa.push_back('{b: r[k], last: (k == FA - 1)});
  endtask

  task automatic push_b(input logic [31:0] w);
    logic [32:0] r;
    r = frame_bits(WB, 1'b0, w);
    for (int unsigned k = 0; k < FB; k++) qb.push_back('{b: r[k], last: (k == FB - 1)});
  endtask

  // Drivers: entered and left at negedge+1; handshake sampled just before posedge.
  task automatic send_a(input logic [WA-1:0] w);
    bit acc;
    acc = 1'b0;
    ifa.in_valid = 1'b1;
    ifa.in_data  = w;
    for (int i = 0; i < 100 && !acc; i++) begin
      #3;
      if (ifa.in_ready) begin
        push_a(32'(w));
        acc = 1'b1;
      end
      @(negedge clk);
      #1;
    end
    check("a_accept", 64'(acc), 64'd1);
    ifa.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [WB-1:0] w);
    bit acc;
    acc = 1'b0;
    ifb.in_valid = 1'b1;
    ifb.in_data  = w;
    for (int i = 0; i < 100 && !acc; i++) begin
      #3;
      if (ifb.in_ready) begin
        push_b(32'(w));
        acc = 1'b1;
      end
      @(negedge clk);
      #1;
    end
    check("b_accept", 64'(acc), 64'd1);
    ifb.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Monitor A: compare presented bit against scoreboard head.
  always @(negedge clk) begin
    ebit_t e;
    bit    have;
    have = (qa.size() != 0);
    check("a_bit_valid", 64'(a_bv), 64'(have));
    check("a_busy", 64'(a_busy), 64'(have));
    if (have) begin
      e = qa.pop_front();
      check("a_ser_out", 64'(a_ser), 64'(e.b));
      check("a_last_bit", 64'(a_last), 64'(e.last));
    end else begin
      check("a_idle_ser", 64'(a_ser), 64'd0);
      check("a_idle_last", 64'(a_last), 64'd0);
    end
    check("a_in_ready", 64'(ifa.in_ready), 64'(qa.size() == 0));
    if (a_bv === 1'b1) begin
      stream_a = {stream_a[62:0], a_ser};
      na++;
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    ebit_t e;
    bit    have;
    have = (qb.size() != 0);
    check("b_bit_valid", 64'(b_bv), 64'(have));
    check("b_busy", 64'(b_busy), 64'(have));
    if (have) begin
      e = qb.pop_front();
      check("b_ser_out", 64'(b_ser), 64'(e.b));
      check("b_last_bit", 64'(b_last), 64'(e.last));
    end else begin
      check("b_idle_ser", 64'(b_ser), 64'd0);
      check("b_idle_last", 64'(b_last), 64'd0);
    end
    check("b_in_ready", 64'(ifb.in_ready), 64'(qb.size() == 0));
    if (b_bv === 1'b1) begin
      stream_b = {stream_b[62:0], b_ser};
      nb++;
    end
  end

  initial begin
    ifa.in_valid = 1'b0;
    ifa.in_data  = '0;
    ifb.in_valid = 1'b0;
    ifb.in_data  = '0;
    stream_a = '0;
    stream_b = '0;
    na = 0;
    nb = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_a_bit_valid", 64'(a_bv), 64'd0);
    check("rst_a_ser", 64'(a_ser), 64'd0);
    check("rst_a_ready", 64'(ifa.in_ready), 64'd1);
    check("rst_b_last", 64'(b_last), 64'd0);
    check("rst_b_ready", 64'(ifb.in_ready), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(2);

    // Directed: single word, then a back-to-back pair on A; 8'hA5 on B.
    stream_a = '0; na = 0;
    stream_b = '0; nb = 0;
    fork
      begin
        send_a(5'b11001);
        idle(8);
        send_a(5'b11001);
        send_a(5'b10011);
        idle(FA + 2);
      end
      begin
        send_b(8'hA5);
        idle(FB + 2);
      end
    join
`ifdef PISO_PARITY_EN
    check("a_stream_len", 64'(na), 64'd18);
    check("a_stream", stream_a, 64'b110011_110011_100111);
    check("b_stream_len", 64'(nb), 64'd9);
    check("b_stream", stream_b, 64'b10100101_0);
`else
    check("a_stream_len", 64'(na), 64'd15);
    check("a_stream", stream_a, 64'b11001_11001_10011);
    check("b_stream_len", 64'(nb), 64'd8);
    check("b_stream", stream_b, 64'b10100101);
`endif

    // Stall: valid pulses mid-frame must be ignored.
    send_b(8'h3C);
    ifb.in_valid = 1'b1;
    ifb.in_data  = 8'h00;
    #3;
    check("b_stall_ready", 64'(ifb.in_ready), 64'd0);
    @(negedge clk);
    #1;
    ifb.in_valid = 1'b0;
    idle(FB + 1);
    send_b(8'h07);
    send_b(8'h03);
    idle(FB + 2);

    // Reset mid-frame after the 3rd bit of 8'hFF.
    send_b(8'hFF);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    qa.delete();
    qb.delete();
    ifb.in_valid = 1'b1;
    ifb.in_data  = 8'h81;
    #1;
    check("rstmid_ser", 64'(b_ser), 64'd0);
    check("rstmid_bit_valid", 64'(b_bv), 64'd0);
    check("rstmid_last", 64'(b_last), 64'd0);
    check("rstmid_ready", 64'(ifb.in_ready), 64'd1);
    idle(2);
    ifb.in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    send_b(8'hC3);
    idle(FB + 2);

    // Randomized traffic with random gaps (gap 0 = back-to-back).
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send_a(WA'($urandom));
          idle(int'($urandom_range(0, 3)));
        end
      end
      begin
        for (int i = 0; i < 150; i++) begin
          send_b(WB'($urandom));
          idle(int'($urandom_range(0, 3)));
        end
      end
    join

    for (int i = 0; i < 100 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    idle(2);
    check("drain_a", 64'(qa.size()), 64'd0);
    check("drain_b", 64'(qb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
